lockin_frame_scheduler: RTL
===========================

Name: lockin_frame_scheduler

Overview:
Sits downstream of the lock-in amplifier and paces its output towards the host link.
- Consumes the lock-in x/y result strobe.
- Boxcar-averages 2^shift consecutive x/y pairs.
- Emits each averaged result as a 3-word frame (header, x, y) on a valid/ready stream.
- Sequences frame emission while the next window accumulates; flags overruns when the link cannot keep up.

Parameters:
NUM_BITS, 24, width of x_i/y_i samples (signed)
SHIFT_W, 4, width of shift_i; max window = 2^(2^SHIFT_W - 1) samples
ACC_BITS, NUM_BITS+2**SHIFT_W, accumulator width (cannot overflow)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-low reset
enable_i  in  1  1 = accumulate; 0 = clear window, ignore samples
shift_i  in  SHIFT_W  log2 of window length
done_i  in  1  one-cycle strobe: x_i/y_i valid this cycle
x_i  in  NUM_BITS  signed in-phase result
y_i  in  NUM_BITS  signed quadrature result
data_o  out  32  frame word
valid_o  out  1  data_o valid
ready_i  in  1  sink accepts data_o when valid_o && ready_i
last_o  out  1  high on the final word (y) of a frame
overrun_o  out  1  sticky: a completed window was dropped
clear_overrun_i  in  1  synchronous clear of overrun_o
seq_o  out  16  number of frames fully emitted (wraps)

Behaviour:
Reset (reset_i=0, async):
- data_o=0, valid_o=0, last_o=0, overrun_o=0, seq_o=0.
- Accumulators and sample counter = 0; FSM in IDLE.

Accumulation:
- On done_i && enable_i: acc_x += sext(x_i); acc_y += sext(y_i); cnt++.
- shift_i is latched on the first sample of a window (cnt==0); changes mid-window have no effect until the next window.
- Window completes on the sample where cnt+1 == 2^shift_latched. In that cycle:
  - avg_x = (acc_x + x_i) >>> shift, arithmetic shift, truncated to NUM_BITS; same for y.
  - acc and cnt clear to 0. The next done_i starts a new window with no gap.
- shift=0: every sample is its own window, avg = sample.
- enable_i=0: acc and cnt clear synchronously each cycle; done_i is ignored; a frame already in flight still completes.

Output FSM: IDLE -> HDR -> XW -> YW -> IDLE.
- IDLE: on window completion, load the frame buffer with avg_x, avg_y and header {8'hA5, 4'h0, shift_latched (zero-extended to 4 bits), seq_o}. Next cycle: HDR, valid_o=1.
  - Latency: done_i completing a window at cycle t gives valid_o=1 at t+1.
- HDR/XW/YW: data_o = header, sext32(avg_x), sext32(avg_y) respectively.
  - Advance only on valid_o && ready_i.
  - data_o, last_o and valid_o are stable while valid_o && !ready_i.
- last_o=1 only in YW.
- On the YW handshake:
  - seq_o++ (wraps 0xFFFF -> 0).
  - If no new window completes that cycle: go to IDLE, valid_o=0.
  - If a window completes in the same cycle: load the new frame and go directly to HDR, valid_o stays 1. This is not an overrun.
- Back-to-back frames: minimum 3 accepted words per frame; no idle cycle is required between frames.

Overrun:
- Trigger: a window completes while the FSM is in HDR/XW/YW, excluding the YW-handshake cycle.
- Effect: the new result is discarded, overrun_o is set, seq_o is unaffected, and the in-flight frame is untouched.
- clear_overrun_i clears overrun_o. If set and clear occur in the same cycle, set wins.
- The sample that triggered the overrun still closes its window (acc/cnt clear).

Test Plan:
- Reset, shift_i=2, enable_i=1, ready_i=1, x_i=100,200,300,400, y_i=-4,-4,-4,-8 on four done_i strobes -> valid_o one cycle after 4th strobe; words 0xA5020000, 0x000000FA, 0xFFFFFFFB; last_o on third word only; seq_o=1.
- shift_i=0, x_i=-1, y_i=0x7FFFFF, ready_i held 0 for 5 cycles -> data_o=0xA5000000 stable and valid_o=1 throughout; after ready_i=1 words 0xFFFFFFFF, 0x007FFFFF; seq_o=1.
- shift_i=0, ready_i=0, two done_i strobes 2 cycles apart -> first frame held, overrun_o=1, second result never emitted; clear_overrun_i pulse -> overrun_o=0.
- shift_i=0, ready_i=1, done_i timed to land on the YW handshake cycle -> next header follows with no valid_o gap, overrun_o stays 0, header seq field is incremented by 1.
- shift_i=3, 5 samples then enable_i=0 for 1 cycle, then 8 samples of x=8 -> exactly one frame, x word 0x00000008 (earlier partial window discarded).
- Assert reset_i low mid-frame in XW -> valid_o, seq_o, overrun_o, and data_o drop to 0 immediately (async), before the next clock edge.

Source files
------------

// File: rtl/lockin_frame_scheduler.sv
// Lock-in result framer: boxcar-averages 2^shift x/y pairs and streams each
// average as a three-word frame (header, x, y) on a valid/ready link.
module lockin_frame_scheduler #(
    parameter int NUM_BITS = 24,
    parameter int SHIFT_W  = 4,
    parameter int ACC_BITS = NUM_BITS + 2**SHIFT_W
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    input  logic                done_i,
    input  logic [NUM_BITS-1:0] x_i,
    input  logic [NUM_BITS-1:0] y_i,
    output logic [31:0]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                overrun_o,
    input  logic                clear_overrun_i,
    output logic [15:0]         seq_o
);

    localparam int CNT_W = 2**SHIFT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XW   = 2'd2,
        ST_YW   = 2'd3
    } state_t;

    state_t                      state_r, state_nxt_s;
    logic signed [ACC_BITS-1:0]  acc_x_r, acc_y_r;
    logic        [CNT_W-1:0]     cnt_r;
    logic        [SHIFT_W-1:0]   shift_r;
    logic        [31:0]          hdr_r;
    logic        [NUM_BITS-1:0]  ax_r, ay_r;

    logic                        sample_s, win_done_s, hs_s, load_s, ovr_set_s;
    logic        [SHIFT_W-1:0]   eff_shift_s;
    logic        [CNT_W:0]       cnt_plus_s, win_len_s;
    logic signed [ACC_BITS-1:0]  x_ext_s, y_ext_s, sum_x_s, sum_y_s;
    logic        [NUM_BITS-1:0]  avg_x_s, avg_y_s, ax_buf_s, ay_buf_s;
    logic        [15:0]          seq_nxt_s;
    logic        [31:0]          hdr_new_s, hdr_buf_s, data_nxt_s;

    // The window length is taken from shift_i on the first sample and from the
    // latched copy afterwards, so mid-window changes are ignored.
    assign sample_s    = done_i && enable_i;
    assign eff_shift_s = (cnt_r == {CNT_W{1'b0}}) ? shift_i : shift_r;
    assign cnt_plus_s  = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign win_len_s   = {{CNT_W{1'b0}}, 1'b1} << eff_shift_s;
    assign win_done_s  = sample_s && (cnt_plus_s == win_len_s);

    assign x_ext_s = {{(ACC_BITS-NUM_BITS){x_i[NUM_BITS-1]}}, x_i};
    assign y_ext_s = {{(ACC_BITS-NUM_BITS){y_i[NUM_BITS-1]}}, y_i};
    assign sum_x_s = acc_x_r + x_ext_s;
    assign sum_y_s = acc_y_r + y_ext_s;
    assign avg_x_s = NUM_BITS'(sum_x_s >>> eff_shift_s);
    assign avg_y_s = NUM_BITS'(sum_y_s >>> eff_shift_s);

    assign hs_s      = valid_o && ready_i;
    assign hdr_new_s = {8'hA5, 4'h0, 4'(eff_shift_s), seq_nxt_s};
    assign hdr_buf_s = load_s ? hdr_new_s : hdr_r;
    assign ax_buf_s  = load_s ? avg_x_s : ax_r;
    assign ay_buf_s  = load_s ? avg_y_s : ay_r;

    // Accumulate samples of the current window; clear on completion or disable.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_x_r <= '0;
            acc_y_r <= '0;
            cnt_r   <= '0;
            shift_r <= '0;
        end else begin
            if (sample_s && (cnt_r == {CNT_W{1'b0}})) begin
                shift_r <= shift_i;
            end
            if (!enable_i || win_done_s) begin
                acc_x_r <= '0;
                acc_y_r <= '0;
                cnt_r   <= '0;
            end else if (sample_s) begin
                acc_x_r <= sum_x_s;
                acc_y_r <= sum_y_s;
                cnt_r   <= cnt_plus_s[CNT_W-1:0];
            end
        end
    end

    // Frame sequencing: next state, frame loads, sequence count and overrun set.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        seq_nxt_s   = seq_o;
        ovr_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_done_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                ovr_set_s = win_done_s;
                if (hs_s) begin
                    state_nxt_s = ST_XW;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_XW: begin
                ovr_set_s = win_done_s;
                if (hs_s) begin
                    state_nxt_s = ST_YW;
                end else begin
                    state_nxt_s = ST_XW;
                end
            end
            ST_YW: begin
                if (hs_s) begin
                    seq_nxt_s = seq_o + 16'd1;
                    if (win_done_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_HDR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    ovr_set_s   = win_done_s;
                    state_nxt_s = ST_YW;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Select the word the link sees in the next cycle.
    always_comb begin
        data_nxt_s = 32'h0000_0000;
        case (state_nxt_s)
            ST_HDR:  data_nxt_s = hdr_buf_s;
            ST_XW:   data_nxt_s = {{(32-NUM_BITS){ax_buf_s[NUM_BITS-1]}}, ax_buf_s};
            ST_YW:   data_nxt_s = {{(32-NUM_BITS){ay_buf_s[NUM_BITS-1]}}, ay_buf_s};
            default: data_nxt_s = 32'h0000_0000;
        endcase
    end

    // Register FSM state, frame buffer and all link-facing outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r   <= ST_IDLE;
            hdr_r     <= '0;
            ax_r      <= '0;
            ay_r      <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            seq_o     <= '0;
        end else begin
            state_r <= state_nxt_s;
            hdr_r   <= hdr_buf_s;
            ax_r    <= ax_buf_s;
            ay_r    <= ay_buf_s;
            data_o  <= data_nxt_s;
            valid_o <= (state_nxt_s != ST_IDLE);
            last_o  <= (state_nxt_s == ST_YW);
            seq_o   <= seq_nxt_s;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            overrun_o <= 1'b0;
        end else if (ovr_set_s) begin
            overrun_o <= 1'b1;
        end else if (clear_overrun_i) begin
            overrun_o <= 1'b0;
        end
    end

endmodule
